// File: rtl/timer_scheduler.sv
// timer_scheduler: round-robin arbiter sharing one terminal-count timer among
// NREQ requesters. The winner's final value is captured at grant, the timer
// counts 0..term, and a one-cycle done pulse goes back to the owner.
//
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous active-high reset
//   req    - per-requester level request
//   value  - per-requester final value, slice i = value[i*N +: N]
//   grant  - one-hot timer owner (zero when idle)
//   done   - one-hot, one-cycle terminal-count pulse to the owner
//   busy   - high whenever the scheduler is not idle
//   count  - current timer value
module timer_scheduler #(
  parameter int unsigned N    = 8,
  parameter int unsigned NREQ = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] value,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [N-1:0]      count
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   ptr, ptr_nx;
  logic [IW-1:0]   owner, owner_nx;
  logic [IW-1:0]   win, cand, next_ptr;
  logic            found;
  logic [N-1:0]    term, term_nx;
  logic [N-1:0]    count_nx;
  logic [NREQ-1:0] grant_nx, done_nx;
  logic            busy_nx;

  // Round-robin search: first asserted request at or after ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    cand  = ptr;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IW'((32'(ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Pointer moves past the current owner whenever a job ends (done or abort).
  always_comb begin
    next_ptr = (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);
  end

  // Next-state and registered-output values.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    owner_nx = owner;
    term_nx  = term;
    count_nx = count;
    grant_nx = grant;
    done_nx  = '0;

    case (state)
      IDLE: begin
        if (found) begin
          owner_nx = win;
          count_nx = '0;
          grant_nx = NREQ'(1) << win;
          state_nx = RUN;
          for (int unsigned i = 0; i < NREQ; i++) begin
            if (win == IW'(i)) term_nx = value[i*N +: N];
          end
        end
      end
      RUN: begin
        // Abort wins over terminal count on the same edge.
        if (!req[owner]) begin
          state_nx = IDLE;
          grant_nx = '0;
          count_nx = '0;
          ptr_nx   = next_ptr;
        end else if (count == term) begin
          state_nx = DONE;
          done_nx  = grant;
        end else begin
          count_nx = count + N'(1);
        end
      end
      DONE: begin
        state_nx = IDLE;
        grant_nx = '0;
        count_nx = '0;
        ptr_nx   = next_ptr;
      end
      default: begin
        state_nx = IDLE;
        grant_nx = '0;
        count_nx = '0;
      end
    endcase

    busy_nx = (state_nx != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
      term  <= '0;
      count <= '0;
      grant <= '0;
      done  <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      owner <= owner_nx;
      term  <= term_nx;
      count <= count_nx;
      grant <= grant_nx;
      done  <= done_nx;
      busy  <= busy_nx;
    end
  end

endmodule

// File: tb/tb_timer_scheduler.sv
// Self-checking bench for timer_scheduler. The reference model tracks the
// current owner and the number of cycles elapsed since grant; expected outputs
// are derived from those with plain arithmetic.
module tb_timer_scheduler;

  localparam int unsigned N    = 8;
  localparam int unsigned NREQ = 4;
  localparam int unsigned VW   = 2*NREQ + N + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] value;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic [N-1:0]      count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: owner (-1 = idle), cycles since grant, captured term, pointer.
  int m_owner = -1;
  int m_k     = 0;
  int m_term  = 0;
  int m_ptr   = 0;

  timer_scheduler #(.N(N), .NREQ(NREQ)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .value (value),
    .grant (grant),
    .done  (done),
    .busy  (busy),
    .count (count)
  );

  always #5 clk = ~clk;

  // Advance one edge, update the model with the inputs sampled at that edge.
  task automatic step();
    int found;
    @(posedge clk);
    cyc++;
    if (reset) begin
      m_owner = -1; m_ptr = 0; m_k = 0; m_term = 0;
    end else if (m_owner < 0) begin
      found = 0;
      for (int k = 0; k < int'(NREQ); k++) begin
        int c;
        c = (m_ptr + k) % int'(NREQ);
        if (found == 0 && req[c]) begin
          found = 1;
          m_owner = c;
        end
      end
      if (found != 0) begin
        m_term = int'(value[m_owner*N +: N]);
        m_k = 0;
      end
    end else if (m_k == m_term + 1) begin
      m_ptr = (m_owner + 1) % int'(NREQ);
      m_owner = -1;
    end else if (!req[m_owner]) begin
      m_ptr = (m_owner + 1) % int'(NREQ);
      m_owner = -1;
    end else begin
      m_k++;
    end
    #1;
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic [NREQ-1:0] g;
    logic [NREQ-1:0] d;
    logic [N-1:0]    c;
    g = (m_owner >= 0) ? (NREQ'(1) << m_owner) : NREQ'(0);
    d = (m_owner >= 0 && m_k == m_term + 1) ? g : NREQ'(0);
    c = (m_owner >= 0) ? N'((m_k > m_term) ? m_term : m_k) : N'(0);
    return {g, d, (m_owner >= 0), c};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {grant, done, busy, count};
  endfunction

  task automatic rand_values();
    for (int i = 0; i < int'(NREQ); i++) value[i*N +: N] = N'($urandom_range(255, 0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; value = '0;
    step(); step();
    if (obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_model got %h exp %h", obs_vec(), exp_vec());
    end
    checks++;
    if ({grant, done, busy, count} !== '0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0", {grant, done, busy, count});
    end
    checks++;
    reset = 1'b0;
  endtask

  task automatic test_single();
    int exp_cnt [5] = '{0, 1, 2, 3, 3};
    rand_values();
    value[0 +: N] = N'(3);
    req = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      step();
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL single_model cyc %0d got %h exp %h", c, obs_vec(), exp_vec());
      end
      checks++;
      if (grant !== 4'b0001 || int'(count) != exp_cnt[c] || done !== ((c == 4) ? 4'b0001 : 4'b0000)) begin
        errors++; $display("FAIL single_seq cyc %0d got grant %b count %0d done %b exp count %0d", c, grant, count, done, exp_cnt[c]);
      end
      checks++;
    end
    req = '0;
    step();
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      errors++; $display("FAIL single_gap got grant %b busy %b exp 0000 0", grant, busy);
    end
    checks++;
  endtask

  task automatic test_round_robin();
    int order [$];
    int exp_order [6] = '{0, 1, 2, 3, 0, 1};
    logic [NREQ-1:0] prev;
    do_reset();
    for (int i = 0; i < int'(NREQ); i++) value[i*N +: N] = N'(1);
    req = 4'b1111;
    prev = '0;
    for (int c = 0; c < 24; c++) begin
      step();
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL rr_model cyc %0d got %h exp %h", c, obs_vec(), exp_vec());
      end
      checks++;
      if (prev == '0 && grant != '0) begin
        for (int i = 0; i < int'(NREQ); i++) if (grant[i]) order.push_back(i);
      end
      prev = grant;
    end
    if (order.size() != 6) begin
      errors++; $display("FAIL rr_count got %0d grants exp 6", order.size());
    end
    checks++;
    for (int i = 0; i < 6 && i < order.size(); i++) begin
      if (order[i] != exp_order[i]) begin
        errors++; $display("FAIL rr_order idx %0d got %0d exp %0d", i, order[i], exp_order[i]);
      end
      checks++;
    end
    req = '0;
    step(); step();
  endtask

  task automatic test_zero();
    rand_values();
    value[2*N +: N] = N'(0);
    req = 4'b0100;
    step();
    if (grant !== 4'b0100 || count !== N'(0) || done !== 4'b0000) begin
      errors++; $display("FAIL zero_run got grant %b count %0d done %b exp 0100 0 0000", grant, count, done);
    end
    checks++;
    step();
    if (grant !== 4'b0100 || count !== N'(0) || done !== 4'b0100) begin
      errors++; $display("FAIL zero_done got grant %b count %0d done %b exp 0100 0 0100", grant, count, done);
    end
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL zero_model got %h exp %h", obs_vec(), exp_vec());
    end
    checks++;
    req = '0;
    step();
  endtask

  task automatic test_abort();
    int hit;
    logic saw_done0;
    do_reset();
    rand_values();
    value[0 +: N] = N'(10);
    value[N +: N] = N'($urandom_range(5, 0));
    req = 4'b0011;
    hit = 0; saw_done0 = 1'b0;
    for (int c = 0; c < 20 && hit == 0; c++) begin
      step();
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL abort_model cyc %0d got %h exp %h", c, obs_vec(), exp_vec());
      end
      checks++;
      if (done[0]) saw_done0 = 1'b1;
      if (grant == 4'b0001 && count == N'(2)) hit = 1;
    end
    if (hit == 0) begin
      errors++; $display("FAIL abort_wait got no count 2 exp count 2 within 20 cycles");
    end
    checks++;
    req[0] = 1'b0;
    step();
    if (done[0]) saw_done0 = 1'b1;
    if (grant !== 4'b0000) begin
      errors++; $display("FAIL abort_drop got grant %b exp 0000", grant);
    end
    checks++;
    step();
    if (grant !== 4'b0010 || count !== N'(0)) begin
      errors++; $display("FAIL abort_next got grant %b count %0d exp 0010 0", grant, count);
    end
    checks++;
    for (int c = 0; c < 10; c++) begin
      step();
      if (done[0]) saw_done0 = 1'b1;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL abort_tail cyc %0d got %h exp %h", c, obs_vec(), exp_vec());
      end
      checks++;
      if (done[1]) req = '0;
    end
    if (saw_done0 !== 1'b0) begin
      errors++; $display("FAIL abort_nodone got done0 seen 1 exp 0");
    end
    checks++;
    req = '0;
    step(); step();
  endtask

  task automatic test_reset_mid();
    int hit;
    do_reset();
    rand_values();
    value[N +: N] = N'(200);
    req = 4'b0010;
    hit = 0;
    for (int c = 0; c < 20 && hit == 0; c++) begin
      step();
      if (grant == 4'b0010 && count == N'(5)) hit = 1;
    end
    if (hit == 0) begin
      errors++; $display("FAIL rstmid_wait got no count 5 exp count 5 within 20 cycles");
    end
    checks++;
    reset = 1'b1;
    step();
    if ({grant, done, busy, count} !== '0) begin
      errors++; $display("FAIL rstmid_outputs got %h exp 0", {grant, done, busy, count});
    end
    checks++;
    reset = 1'b0;
    req = 4'b1111;
    step();
    if (grant !== 4'b0001 || count !== N'(0)) begin
      errors++; $display("FAIL rstmid_regrant got grant %b count %0d exp 0001 0", grant, count);
    end
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL rstmid_model got %h exp %h", obs_vec(), exp_vec());
    end
    checks++;
    req = '0;
    step(); step();
  endtask

  task automatic test_value_max();
    int run_cycles;
    int hit;
    logic [N-1:0] last;
    do_reset();
    rand_values();
    value[3*N +: N] = N'(255);
    req = 4'b1000;
    step();
    value[3*N +: N] = N'(4);
    run_cycles = 1; hit = 0; last = count;
    for (int c = 0; c < 300 && hit == 0; c++) begin
      step();
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL max_model cyc %0d got %h exp %h", c, obs_vec(), exp_vec());
      end
      checks++;
      if (done != '0) hit = 1;
      else if (grant == 4'b1000) run_cycles++;
      if (count < last && hit == 0) begin
        errors++; $display("FAIL max_wrap got count %0d after %0d exp monotonic", count, last);
      end
      last = count;
    end
    if (hit == 0 || run_cycles != 256 || done !== 4'b1000 || count !== N'(255)) begin
      errors++; $display("FAIL max_done got run %0d done %b count %0d exp 256 1000 255", run_cycles, done, count);
    end
    checks++;
    req = '0;
    step(); step();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(199, 0) == 0);
      for (int i = 0; i < int'(NREQ); i++) begin
        value[i*N +: N] = N'($urandom_range(7, 0));
        if (req[i]) begin
          if (done[i] && $urandom_range(1, 0) == 0) req[i] = 1'b0;
          else if ($urandom_range(31, 0) == 0) req[i] = 1'b0;
        end else if ($urandom_range(3, 0) == 0) begin
          req[i] = 1'b1;
        end
      end
      step();
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL random_model cyc %0d got %h exp %h", c, obs_vec(), exp_vec());
      end
      checks++;
    end
    reset = 1'b0;
    req = '0;
    step(); step();
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    value = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_zero();
    test_abort();
    test_reset_mid();
    test_value_max();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_scheduler.md
# timer_scheduler

Round-robin scheduler that shares a single terminal-count timer among `NREQ` requesters. Each requester raises a request together with its own final value. The scheduler grants the timer to one requester at a time, runs the count from 0 up to that requester's value, and returns a one-cycle done pulse to the owner. It sits in front of the counter/timer datapath so that several control blocks can time intervals without each instantiating its own counter.

## Interface
- `N`, default 8: counter and final-value width in bits.
- `NREQ`, default 4: number of requesters (≥2).

- `clk`, input, 1: clock; all logic on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `req`, input, NREQ: level request per requester; held high until done or until the requester abandons.
- `value`, input, NREQ*N: per-requester final value; slice i is bits [i*N +: N].
- `grant`, output, NREQ: one-hot owner of the timer; all zero when idle.
- `done`, output, NREQ: one-hot, one-cycle pulse to the owner on terminal count.
- `busy`, output, 1: high whenever state ≠ IDLE.
- `count`, output, N: current timer value.

## Operation
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - If `req` ≠ 0 at an edge, select the winner g by round-robin search starting at pointer `ptr` and ascending mod NREQ.
  - On that edge: latch `term` ← value slice g, `count` ← 0, `grant` ← onehot(g), state ← RUN.
  - If `req` = 0, remain in IDLE.
- RUN:
  - If `req[g]` = 0 at an edge (abort): state ← IDLE, `grant` ← 0, `count` ← 0, `ptr` ← (g+1) mod NREQ. No done pulse.
  - Otherwise, if `count` == `term`: state ← DONE, `done` ← onehot(g), `count` holds `term`.
  - Otherwise: `count` ← `count`+1.
  - Abort takes priority over terminal count on the same edge.
- DONE:
  - Lasts exactly one cycle; `req` is ignored.
  - Next edge: state ← IDLE, `grant` ← 0, `done` ← 0, `count` ← 0, `ptr` ← (g+1) mod NREQ.
- `term` is captured only at grant. Changes to `value` during RUN or DONE have no effect.
- `value` = 0 is legal and yields one RUN cycle followed by DONE.
- `value` = 2^N−1 is legal. `count` reaches 2^N−1 and never wraps before done.
- A requester still high in IDLE after its own done is re-arbitrated normally. Because `ptr` has advanced, all other pending requesters are served first.
- Reset values: state IDLE, `grant` 0, `done` 0, `busy` 0, `count` 0, `ptr` 0, `term` 0. Reset overrides every other condition, including mid-RUN and DONE, and no done pulse is issued for the interrupted job.

## Timing
- Request to grant: 1 edge. `grant` is visible in the cycle after the IDLE edge that samples `req`.
- A job with value V occupies V+1 RUN cycles (`count` = 0..V), then 1 DONE cycle. `grant` is high for V+2 cycles; `done` is high in the last of them.
- Between jobs there is at least 1 IDLE cycle with `grant` = 0, so the grant period for back-to-back requests is V+3 cycles.
- `done` and `grant` are never asserted to different requesters in the same cycle.
- `busy` = 1 for exactly the cycles in which `grant` ≠ 0.

## Test plan
1. Single job: reset, then `req`=0001 with value0=3. Required: `grant`=0001 for 5 cycles; `count` reads 0,1,2,3,3; `done`=0001 only in the 5th cycle; then 1 cycle with `grant`=0 and `busy`=0.
2. Round-robin fairness: `req`=1111 held, all values 1. Required: grant order 0,1,2,3,0,1; each grant lasts 3 cycles with a 1-cycle idle gap; each `done` pulse goes to the current owner only.
3. Zero value: `req`=0100 with value2=0. Required: `grant`=0100 for 2 cycles, `count`=0 throughout, `done`=0100 in the 2nd cycle.
4. Abort: `req`=0011 with value0=10. Drop `req[0]` when `count`=2. Required: next cycle `grant`=0 and no `done[0]` ever; the following grant is 0010, starting at `count` 0.
5. Reset mid-run: value1=200 granted, assert `reset` at `count`=5. Required: next cycle state IDLE, all outputs 0, no done. Then with `req`=1111, requester 0 is granted first (`ptr`=0).
6. Value capture and maximum: grant requester 3 with value3=255, change value3 to 4 during RUN. Required: `count` runs to 255 without wrap and `done`=1000 after 256 RUN cycles; the changed value is ignored.
